ddr_ib_packer: RTL and testbench
================================

# ddr_ib_packer

Packs the 16-bit sample word stream from the acquisition logic into 32-bit entries for the DDR input buffer FIFO. The SDRAM write state machine drains that FIFO only in whole bursts, so this block also handles flushing. On request, it pads the stream with fill words until the FIFO contents end on a burst boundary, which leaves no stranded 1–3 words when sampling stops.

## Interface
- FIFO_DEPTH, 2048: input FIFO depth in 32-bit entries.
- FILL_WORD, 16'h0000: 16-bit pad value inserted during flush.
- SPACE_MARGIN, 8: entries kept free to cover `ib_count` reporting lag.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample word valid.
- in_data  in  16  sample word.
- in_ready  out  1  word accepted on a cycle where `in_valid && in_ready`.
- burst_len  in  6  32-bit entries per DDR burst; legal values are even, 2..32.
- flush_req  in  1  single-cycle pulse requesting pad-to-boundary.
- flush_busy  out  1  high while padding.
- flush_done  out  1  single-cycle pulse; FIFO contents are burst-aligned.
- ib_we  out  1  input FIFO write enable.
- ib_din  out  32  input FIFO write data.
- ib_count  in  11  input FIFO fill level.
- pad_count  out  7  fill words inserted by the last flush.
- word_count  out  32  total 32-bit entries written, wrapping.

## Operation
- Packing order:
  - The first accepted word is held as the low half and goes to `ib_din[15:0]`.
  - The second accepted word goes to `ib_din[31:16]`; the pair is written as one entry.
  - `half_pend` flags a held low half.
- `beat_cnt` counts entries written modulo `act_len`.
- `act_len` latches `burst_len` only when `beat_cnt==0 && !half_pend`. A `burst_len` that is odd, 0, or >32 latches as 2.
- `space_ok = ib_count < FIFO_DEPTH-SPACE_MARGIN`.
- States:
  - S_RUN: `in_ready = space_ok`. A `flush_req` pulse goes to S_PAD if `half_pend || beat_cnt!=0`; otherwise it goes to S_DONE.
  - S_PAD: `in_ready=0`, `flush_busy=1`. Each cycle with `space_ok`:
    - Write one entry. A held low half is completed with FILL_WORD; otherwise the entry is {FILL_WORD, FILL_WORD}.
    - `pad_count` increments by 1 or 2 accordingly.
    - Leave for S_DONE on the write that brings `beat_cnt` to 0.
  - S_DONE: `flush_done=1` for one cycle, `in_ready=0`, then return to S_RUN.
- `pad_count` clears on entering S_PAD. An already-aligned flush leaves it at 0.
- If `flush_req` and an accepted word occur in the same S_RUN cycle, the word is taken first and the flush accounts for it.
- `flush_req` in S_PAD or S_DONE is ignored.
- Maximum pad is 2*32-1 = 63 fill words, which fits `pad_count` width 7.
- `reset_n` low mid-flush aborts immediately. Any held half is discarded and the state returns to S_RUN.

## Timing
- Reset values:
  - `in_ready=0`, `ib_we=0`, `ib_din=0`, `flush_busy=0`, `flush_done=0`, `pad_count=0`, `word_count=0`.
  - State is S_RUN, `half_pend=0`, `beat_cnt=0`, `act_len=2`.
- `in_ready` is registered and may first be high in the first cycle after `reset_n` deasserts.
- Write latency: the second word of a pair accepted at edge N gives `ib_we=1` in cycle N+1 with the packed data. All write outputs are registered.
- `ib_we` is at most one pulse per cycle. Sustained accept rate is one word per cycle, so up to one write every 2 cycles.
- Flush latency: `flush_req` at edge N gives S_PAD at N+1 and the first pad write at N+2 if `space_ok`. `flush_done` pulses the cycle after the final pad write is issued.
- `in_ready` low is back-pressure. The upstream holds `in_data` until it is accepted.

## Configuration
- `DDR_IB_PACKER_STATS_EN`:
  - Defined: the `word_count` and `pad_count` counters are built.
  - Undefined: both outputs are tied to 0, and packing/flush behaviour is unchanged.

## Structure
- Shared package `ddr_pkg` holds:
  - the state enum (S_RUN, S_PAD, S_DONE);
  - `DDR_FIFO_DEPTH=2048`, `DDR_MAX_BURST=32`, `DDR_MIN_BURST=2`;
  - the burst_len sanitising function.
- No sub-module. Single FSM plus datapath.

## Test plan
- Reset, then 8 words 0x0001..0x0008 with `burst_len=2` → 4 writes: 0x00020001, 0x00040003, 0x00060005, 0x00080007; `word_count=4`.
- 5 words with `burst_len=2`, then `flush_req` → entries 3 and 4 are {FILL,0x0005} and {FILL,FILL}; `pad_count=3`; `flush_done` one cycle; `flush_busy` high for 2 cycles.
- Flush with 4 words already written at `burst_len=2` → no writes, `pad_count=0`, `flush_done` 2 cycles after `flush_req`.
- `ib_count=2040` with `in_valid` held high → `in_ready=0`, no `ib_we`. Dropping `ib_count` to 2000 resumes acceptance with no word lost or duplicated.
- `burst_len` changed 32→2 mid-burst → `act_len` stays 32 until `beat_cnt` wraps. A flush with 3 entries written pads 29 entries, giving `pad_count=58`.
- `reset_n` asserted during S_PAD → all outputs at reset values asynchronously. After release, the next words pack from the low half.

Source files
------------

// File: rtl/ddr_pkg.sv
// ddr_pkg: shared definitions for the DDR input-buffer path.
// Holds the packer state encoding, the burst limits and the helper
// that turns an arbitrary burst_len request into a usable burst size.
package ddr_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PAD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DDR_FIFO_DEPTH = 2048;
    localparam int DDR_MAX_BURST  = 32;
    localparam int DDR_MIN_BURST  = 2;

    // Odd, too-small or too-large burst requests fall back to the minimum burst.
    function automatic logic [5:0] sanitize_burst_len(input logic [5:0] len);
        if (len[0] || (int'(len) < DDR_MIN_BURST) || (int'(len) > DDR_MAX_BURST)) begin
            return 6'(DDR_MIN_BURST);
        end
        return len;
    endfunction

endpackage

// File: rtl/ddr_ib_packer.sv
// ddr_ib_packer: packs 16-bit sample words into 32-bit DDR input FIFO
// entries and, on request, pads the stream with FILL_WORD until the FIFO
// contents end on a burst boundary.
// Optional macro DDR_IB_PACKER_STATS_EN builds the pad_count/word_count
// statistics counters; without it both outputs read as zero.
module ddr_ib_packer
    import ddr_pkg::*;
#(
    parameter int          FIFO_DEPTH   = DDR_FIFO_DEPTH,
    parameter logic [15:0] FILL_WORD    = 16'h0000,
    parameter int          SPACE_MARGIN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic [5:0]  burst_len,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        flush_done,
    output logic        ib_we,
    output logic [31:0] ib_din,
    input  logic [10:0] ib_count,
    output logic [6:0]  pad_count,
    output logic [31:0] word_count
);

    state_t      state;
    state_t      state_nxt;
    logic        half_pend;
    logic        half_nxt;
    logic [15:0] low_half;
    logic [5:0]  beat_cnt;
    logic [5:0]  beat_plus;
    logic [5:0]  beat_inc;
    logic [5:0]  beat_nxt;
    logic [5:0]  act_len;
    logic        accept;
    logic        space_ok;
    logic        wr_run;
    logic        wr_pad;
    logic        do_wr;
    logic [31:0] wr_data;

    assign accept    = in_valid && in_ready;
    assign space_ok  = 32'(ib_count) < 32'(FIFO_DEPTH - SPACE_MARGIN);
    assign beat_plus = beat_cnt + 6'd1;
    assign beat_inc  = (beat_plus == act_len) ? 6'd0 : beat_plus;

    // Decide this cycle's write, the next packing position and the next state.
    always_comb begin
        wr_run    = (state == S_RUN) && accept && half_pend;
        wr_pad    = (state == S_PAD) && space_ok;
        do_wr     = wr_run || wr_pad;
        wr_data   = {in_data, low_half};
        half_nxt  = half_pend;
        state_nxt = state;
        if (wr_pad) begin
            wr_data = half_pend ? {FILL_WORD, low_half} : {FILL_WORD, FILL_WORD};
        end
        if ((state == S_RUN) && accept) begin
            half_nxt = !half_pend;
        end else if (wr_pad) begin
            half_nxt = 1'b0;
        end
        beat_nxt = do_wr ? beat_inc : beat_cnt;
        case (state)
            S_RUN: begin
                if (flush_req) begin
                    state_nxt = (half_nxt || (beat_nxt != 6'd0)) ? S_PAD : S_DONE;
                end
            end
            S_PAD: begin
                if (wr_pad && (beat_inc == 6'd0)) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Flush FSM, packing registers and all registered handshake/write outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RUN;
            half_pend  <= 1'b0;
            low_half   <= '0;
            beat_cnt   <= '0;
            act_len    <= 6'(DDR_MIN_BURST);
            in_ready   <= 1'b0;
            ib_we      <= 1'b0;
            ib_din     <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            half_pend <= half_nxt;
            beat_cnt  <= beat_nxt;
            if ((state == S_RUN) && accept && !half_pend) begin
                low_half <= in_data;
            end
            if ((beat_cnt == 6'd0) && !half_pend) begin
                act_len <= sanitize_burst_len(burst_len);
            end
            in_ready   <= (state_nxt == S_RUN) && space_ok;
            ib_we      <= do_wr;
            if (do_wr) begin
                ib_din <= wr_data;
            end
            flush_busy <= (state_nxt == S_PAD);
            flush_done <= (state == S_DONE);
        end
    end

`ifdef DDR_IB_PACKER_STATS_EN
    logic [6:0]  pad_cnt_q;
    logic [31:0] word_cnt_q;

    // Statistics: entries written in total and fill words added by the latest flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            if (do_wr) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if ((state == S_RUN) && flush_req) begin
                pad_cnt_q <= '0;
            end else if (wr_pad) begin
                pad_cnt_q <= pad_cnt_q + (half_pend ? 7'd1 : 7'd2);
            end
        end
    end

    assign pad_count  = pad_cnt_q;
    assign word_count = word_cnt_q;
`else
    assign pad_count  = '0;
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_ddr_ib_packer.sv
// tb_ddr_ib_packer: self-checking bench for ddr_ib_packer.
// A word-stream model (position within the current burst, pending low half,
// remaining pad words) predicts every output each cycle; directed sequences
// pin the model with hand-computed values, then random traffic follows.
module tb_ddr_ib_packer;

    localparam logic [15:0] FILL = 16'h0000;
`ifdef DDR_IB_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [5:0]  burst_len;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;
    logic        ib_we;
    logic [31:0] ib_din;
    logic [10:0] ib_count;
    logic [6:0]  pad_count;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;

    ddr_ib_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .burst_len  (burst_len),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .ib_we      (ib_we),
        .ib_din     (ib_din),
        .ib_count   (ib_count),
        .pad_count  (pad_count),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int          m_pos;
    bit          m_have_low;
    logic [15:0] m_low;
    int          m_len;
    bit          m_flushing;
    int          m_rem;
    int          m_pad;
    int          m_words;
    bit          exp_we;
    logic [31:0] exp_din;
    bit          exp_ready;
    bit          exp_busy;
    bit          exp_done;

    logic [31:0] wr_log[$];
    int          busy_cycles;
    int          done_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int legal_len(input logic [5:0] b);
        int v;
        v = int'(b);
        return ((v >= 2) && (v <= 32) && (v % 2 == 0)) ? v : 2;
    endfunction

    // Reference model: advances the word stream once per clock edge.
    always @(posedge clk or negedge reset_n) begin
        bit space;
        if (!reset_n) begin
            m_pos = 0; m_have_low = 0; m_low = '0; m_len = 2;
            m_flushing = 0; m_rem = 0; m_pad = 0; m_words = 0;
            exp_we = 0; exp_din = '0; exp_ready = 0; exp_busy = 0; exp_done = 0;
        end else begin
            space    = int'(ib_count) < 2040;
            exp_we   = 0;
            exp_done = 0;
            if (m_pos == 0) m_len = legal_len(burst_len);
            if (m_flushing) begin
                if (m_rem == 0) begin
                    m_flushing = 0;
                    exp_done   = 1;
                end else if (space) begin
                    if (m_have_low) begin
                        exp_din = {FILL, m_low};
                        m_have_low = 0; m_rem -= 1; m_pad += 1; m_pos += 1;
                    end else begin
                        exp_din = {FILL, FILL};
                        m_rem -= 2; m_pad += 2; m_pos += 2;
                    end
                    exp_we = 1;
                    m_words++;
                    if (m_pos >= 2 * m_len) m_pos = 0;
                end
            end else begin
                if (in_valid && in_ready) begin
                    if (m_have_low) begin
                        exp_din = {in_data, m_low};
                        exp_we = 1;
                        m_words++;
                        m_have_low = 0;
                    end else begin
                        m_low = in_data;
                        m_have_low = 1;
                    end
                    m_pos++;
                    if (m_pos == 2 * m_len) m_pos = 0;
                end
                if (flush_req) begin
                    m_flushing = 1;
                    m_pad = 0;
                    m_rem = (m_pos == 0) ? 0 : 2 * m_len - m_pos;
                end
            end
            exp_busy  = m_flushing && (m_rem > 0);
            exp_ready = !m_flushing && space;
        end
    end

    task automatic check_output();
        check("ib_we", 32'(ib_we), 32'(exp_we));
        if (exp_we) check("ib_din", ib_din, exp_din);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("flush_busy", 32'(flush_busy), 32'(exp_busy));
        check("flush_done", 32'(flush_done), 32'(exp_done));
        check("pad_count", 32'(pad_count), STATS ? 32'(m_pad) : 32'd0);
        check("word_count", word_count, STATS ? 32'(m_words) : 32'd0);
    endtask

    // Compare process: every cycle out of reset, DUT against model.
    always @(negedge clk) begin
        if (reset_n) begin
            check_output();
            if (ib_we) wr_log.push_back(ib_din);
            if (flush_busy) busy_cycles++;
            if (flush_done) done_cycles++;
        end
    end

    task automatic send_word(input logic [15:0] v);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: word %0h not accepted within 200 cycles", v);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Pulse flush_req and return the number of cycles until flush_done is seen.
    task automatic apply_stimulus_flush(output int lat);
        in_valid  = 1'b0;
        flush_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            flush_req = 1'b0;
        end while (!flush_done && lat < 300);
        if (!flush_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL flush_timeout: flush_done not seen after %0d cycles", lat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ib_we"}, 32'(ib_we), 32'd0);
        check({tag, "_ib_din"}, ib_din, 32'd0);
        check({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
        check({tag, "_flush_done"}, 32'(flush_done), 32'd0);
        check({tag, "_pad_count"}, 32'(pad_count), 32'd0);
        check({tag, "_word_count"}, word_count, 32'd0);
    endtask

    task automatic apply_stimulus_random(input int cycles);
        logic [5:0] lens[12];
        bit rdy_prev;
        lens = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd6, 6'd0, 6'd1, 6'd33, 6'd63, 6'd31, 6'd12};
        rdy_prev = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!in_valid || rdy_prev) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = 16'($urandom);
            end
            flush_req = ($urandom % 32) == 0;
            if ($urandom % 20 == 0) burst_len = lens[$urandom % 12];
            if ($urandom % 16 == 0) begin
                ib_count = ($urandom % 8 == 0) ? 11'($urandom_range(2040, 2047))
                                                : 11'($urandom_range(0, 2039));
            end
            rdy_prev = in_ready;
        end
        @(negedge clk);
        flush_req = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        int lat;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; burst_len = 6'd2;
        flush_req = 1'b0; ib_count = '0; busy_cycles = 0; done_cycles = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Plain packing, burst 2
        wr_log.delete();
        for (int i = 1; i <= 8; i++) send_word(16'(i));
        idle(3);
        check("pack_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            check("pack0", wr_log[0], 32'h0002_0001);
            check("pack1", wr_log[1], 32'h0004_0003);
            check("pack2", wr_log[2], 32'h0006_0005);
            check("pack3", wr_log[3], 32'h0008_0007);
        end
        check("model_words4", 32'(m_words), 32'd4);

        // Five words then flush: one half-fill entry, one full-fill entry
        wr_log.delete();
        for (int i = 1; i <= 5; i++) send_word(16'h0010 + 16'(i));
        busy_cycles = 0; done_cycles = 0;
        apply_stimulus_flush(lat);
        check("unaligned_flush_latency", 32'(lat), 32'd4);
        idle(3);
        check("unaligned_entries", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            check("unaligned_e3", wr_log[2], {FILL, 16'h0015});
            check("unaligned_e4", wr_log[3], {FILL, FILL});
        end
        check("model_pad3", 32'(m_pad), 32'd3);
        check("busy_cycles", 32'(busy_cycles), 32'd2);
        check("done_cycles", 32'(done_cycles), 32'd1);

        // Aligned flush: no writes, done two cycles after the request
        for (int i = 1; i <= 4; i++) send_word(16'h0020 + 16'(i));
        idle(2);
        wr_log.delete();
        apply_stimulus_flush(lat);
        check("aligned_flush_latency", 32'(lat), 32'd2);
        idle(2);
        check("aligned_no_writes", 32'(wr_log.size()), 32'd0);
        check("model_pad0", 32'(m_pad), 32'd0);

        // Back-pressure from a nearly full FIFO
        wr_log.delete();
        ib_count = 11'd2040;
        idle(2);
        in_valid = 1'b1;
        in_data  = 16'h0031;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_ib_we", 32'(ib_we), 32'd0);
        end
        ib_count = 11'd2000;
        for (int i = 1; i <= 4; i++) send_word(16'h0030 + 16'(i));
        idle(3);
        check("resume_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("resume0", wr_log[0], 32'h0032_0031);
            check("resume1", wr_log[1], 32'h0034_0033);
        end

        // Burst length change mid-burst keeps the latched length
        burst_len = 6'd32;
        idle(2);
        for (int i = 1; i <= 6; i++) send_word(16'h0040 + 16'(i));
        burst_len = 6'd2;
        idle(3);
        check("model_len32", 32'(m_len), 32'd32);
        wr_log.delete();
        apply_stimulus_flush(lat);
        idle(2);
        check("long_pad_entries", 32'(wr_log.size()), 32'd29);
        check("model_pad58", 32'(m_pad), 32'd58);

        // Reset while padding
        burst_len = 6'd8;
        idle(2);
        for (int i = 1; i <= 5; i++) send_word(16'h0050 + 16'(i));
        ib_count  = 11'd2045;
        in_valid  = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (4) @(negedge clk);
        check("pad_stall_busy", 32'(flush_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n  = 1'b1;
        ib_count = '0;
        burst_len = 6'd2;
        @(negedge clk);
        wr_log.delete();
        send_word(16'h00A1);
        send_word(16'h00A2);
        idle(3);
        check("post_reset_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() == 1) check("post_reset_pack", wr_log[0], 32'h00A2_00A1);

        // Random traffic, then drain with a final flush
        apply_stimulus_random(3000);
        ib_count = '0;
        idle(4);
        apply_stimulus_flush(lat);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
